bp_fe_pc_seq: RTL
=================

Name: bp_fe_pc_seq

Overview:
Parametrised next-generation front-end PC sequencer.
- Generates fetch PCs for the I$/ITLB and tracks a configurable number of in-flight fetch stages.
- Delivers completed fetches to the FE queue.
- Applies predecode overrides (taken branch, call, return) from the final stage.
- Sits between the BE command decoder (redirects) and the I$/FE queue. Replaces the fixed two-stage sequencer, with depth, fetch width and an optional return-address stack (RAS) all parametrised.

Parameters:
vaddr_width_p, 39, virtual address width
fetch_bytes_p, 4, bytes per fetch; sequential PC increment (power of 2)
stages_p, 2, in-flight fetch stages; legal range 2..4
ras_depth_p, 8, RAS entries (power of 2, ≥2)
boot_pc_p, 'h80000000, value of npc_r after reset

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous, active-low reset
redirect_v_i  in  1  BE redirect, always accepted
redirect_pc_i  in  vaddr_width_p  redirect target
fetch_v_o  out  1  fetch request valid
fetch_pc_o  out  vaddr_width_p  fetch PC
fetch_ready_i  in  1  I$ accepts the request this cycle
poison_o  out  stages_p  per-stage kill; bit i set when stage i is flushed this cycle
resp_v_i  in  1  I$ response for the final stage valid
resp_miss_i  in  1  response is an I$ miss
resp_kind_i  in  2  predecode kind: 0 none, 1 taken branch/jal, 2 call, 3 return
resp_tgt_i  in  vaddr_width_p  predecoded target (kind 1/2)
out_v_o  out  1  delivered fetch valid
out_pc_o  out  vaddr_width_p  PC of the delivered fetch
out_ready_i  in  1  FE queue ready
ras_empty_o  out  1  RAS holds no entries

Behaviour:
Reset (asynchronous, reset_n_i=0):
- state=e_idle; all stage valids 0; npc_r=boot_pc_p; RAS count 0.
- Outputs: fetch_v_o=0, out_v_o=0, poison_o=0, ras_empty_o=1.

Pipeline:
- stage[0..stages_p-1] = {v, pc}; the pipeline shifts every cycle and never holds.
- stage[0] loads fetch_pc_o with v = fetch_v_o & fetch_ready_i.
- Final stage S = stages_p-1; resp_* are aligned to stage S.

Deliver and fail:
- deliver = S.v & resp_v_i & ~resp_miss_i & out_ready_i. out_v_o = deliver; out_pc_o = S.pc.
- fail = S.v & ~deliver.
- On fail:
  - Flush all stages and set poison_o to all ones.
  - npc_r <= S.pc; fetch_v_o=0 this cycle; state <= e_stall.

Override (deliver only):
- ovr = deliver & (kind 1, or kind 2, or kind 3 with RAS non-empty).
- Flushes stages 0..S-1; the corresponding poison bits are set.
- Override target:
  - kind 1/2: resp_tgt_i.
  - kind 3: RAS top.
- Kind 2 also pushes S.pc+fetch_bytes_p onto the RAS. Kind 3 pops.

Next PC, in priority order:
1. redirect_v_i → redirect_pc_i. Flushes all stages, poison all ones, state <= e_run, overrides fail.
2. ovr → override target.
3. Otherwise npc_r.
- On issue: npc_r <= fetch_pc_o + fetch_bytes_p, modulo 2^vaddr_width_p (wraps silently).
- If no issue, npc_r keeps the chosen next PC, so an override or redirect target is never lost.

fetch_v_o:
- redirect_v_i, OR
- state e_run & ~fail, OR
- state e_stall & out_ready_i.

FSM:
- e_idle: → e_run only on redirect_v_i.
- e_stall: → e_run when fetch_v_o & fetch_ready_i; redirect also → e_run.
- e_run: → e_stall on fail without redirect; otherwise stays in e_run.

RAS:
- Circular buffer with pointer and count.
- Push when full: overwrites the oldest entry; count saturates at ras_depth_p.
- Pop when empty: no pointer change, no override; the return is treated as sequential.
- Redirect does not alter the RAS.
- ras_empty_o = (count == 0).

Simultaneous events:
- Redirect with deliver: out_v_o still asserts for S, but no override and no RAS update.

Optional Feature:
BP_FE_PC_SEQ_RAS_EN
- Defined: RAS instantiated as described above.
- Undefined:
  - No RAS storage.
  - Kind 3 treated as kind 0; kind 2 treated as kind 1, with no push.
  - ras_empty_o tied to 1.

Test Plan:
- Reset, redirect 0x1000, fetch_ready_i=1, out_ready_i=1, no misses:
  - fetch PCs 0x1000, 0x1004, 0x1008…; first out_v_o on cycle stages_p after the first issue, out_pc_o 0x1000.
- resp_miss_i on out PC 0x1008 (stages_p=3):
  - poison_o=3'b111, fetch_v_o=0 that cycle; e_stall; next issued PC is 0x1008.
- Deliver 0x2000 with kind 2, target 0x3000:
  - younger stages poisoned; next fetch 0x3000; RAS top 0x2004.
  - Later kind 3 → fetch 0x2004, ras_empty_o=1.
- Nine calls with ras_depth_p=8:
  - the oldest return address is lost; eight returns pop in LIFO order; the ninth return with an empty RAS falls through sequential.
- redirect_v_i in the same cycle as a fail and a fetch_ready_i drop:
  - fetch_pc_o=redirect_pc_i, state e_run, redirect target held until accepted.
- npc_r=0x7F_FFFF_FFFC with vaddr_width_p=39:
  - next sequential PC is 0x0.

Source files
------------

// File: rtl/bp_fe_pc_seq.sv
// bp_fe_pc_seq: front-end PC sequencer with parametrised fetch depth.
// Issues fetch PCs, tracks in-flight fetches, delivers to the FE queue.
//
// Ports:
//   clk_i, reset_n_i          clock, async active-low reset
//   redirect_v_i/_pc_i        BE redirect (always accepted)
//   fetch_v_o/_pc_o/_ready_i  I$/ITLB fetch request handshake
//   poison_o                  per-stage kill for the in-flight fetches
//   resp_v_i/_miss_i          I$ response aligned to the final stage
//   resp_kind_i/_tgt_i        predecode: 0 none, 1 jump, 2 call, 3 return
//   out_v_o/_pc_o/_ready_i    delivery to the FE queue
//   ras_empty_o               return-address stack holds no entries
//
// Optional feature: define BP_FE_PC_SEQ_RAS_EN to build the return-address
// stack. Without it calls act as plain jumps and returns as sequential.

module bp_fe_pc_seq #(
    parameter int vaddr_width_p = 39,
    parameter int fetch_bytes_p = 4,
    parameter int stages_p      = 2,
    parameter int ras_depth_p   = 8,
    parameter logic [vaddr_width_p-1:0] boot_pc_p =
        vaddr_width_p'(32'h8000_0000)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     redirect_v_i,
    input  logic [vaddr_width_p-1:0] redirect_pc_i,

    output logic                     fetch_v_o,
    output logic [vaddr_width_p-1:0] fetch_pc_o,
    input  logic                     fetch_ready_i,

    output logic [stages_p-1:0]      poison_o,

    input  logic                     resp_v_i,
    input  logic                     resp_miss_i,
    input  logic [1:0]               resp_kind_i,
    input  logic [vaddr_width_p-1:0] resp_tgt_i,

    output logic                     out_v_o,
    output logic [vaddr_width_p-1:0] out_pc_o,
    input  logic                     out_ready_i,

    output logic                     ras_empty_o
);

    localparam int S = stages_p - 1;
    localparam logic [vaddr_width_p-1:0] FB =
        vaddr_width_p'(fetch_bytes_p);
    localparam logic [stages_p-1:0] YOUNG =
        {1'b0, {(stages_p-1){1'b1}}};

    typedef enum logic [1:0] {
        e_idle,
        e_run,
        e_stall
    } state_e;

    state_e state_q, state_d;

    logic [vaddr_width_p-1:0] npc_q, npc_d;
    logic [stages_p-1:0]      sv_q;
    logic [vaddr_width_p-1:0] spc_q [stages_p];

    logic                     s_v;
    logic [vaddr_width_p-1:0] s_pc;
    logic                     deliver;
    logic                     fail;
    logic                     k_tgt;
    logic                     k_ret;
    logic                     ovr;
    logic [vaddr_width_p-1:0] ovr_pc;
    logic                     issue;

    assign s_v  = sv_q[S];
    assign s_pc = spc_q[S];

    assign deliver = s_v & resp_v_i & ~resp_miss_i & out_ready_i;
    assign fail    = s_v & ~deliver;

    assign out_v_o  = deliver;
    assign out_pc_o = s_pc;

    // A call is a jump to the predecoded target in both builds.
    assign k_tgt = (resp_kind_i == 2'd1) | (resp_kind_i == 2'd2);

`ifdef BP_FE_PC_SEQ_RAS_EN

    localparam int RW = (ras_depth_p > 1) ? $clog2(ras_depth_p) : 1;
    localparam int CW = RW + 1;

    logic [vaddr_width_p-1:0] ras_mem_q [ras_depth_p];
    logic [RW-1:0]            ras_ptr_q, ras_ptr_d;
    logic [CW-1:0]            ras_cnt_q, ras_cnt_d;
    logic [vaddr_width_p-1:0] ras_top;
    logic                     ras_push;
    logic                     ras_pop;

    // ras_ptr_q names the next free slot; the top is the one below it.
    assign ras_top     = ras_mem_q[ras_ptr_q - RW'(1)];
    assign ras_empty_o = (ras_cnt_q == '0);

    // A return on an empty stack is left to fall through sequentially.
    assign k_ret  = (resp_kind_i == 2'd3) & ~ras_empty_o;
    assign ovr_pc = k_ret ? ras_top : resp_tgt_i;

    assign ras_push = ovr & (resp_kind_i == 2'd2);
    assign ras_pop  = ovr & k_ret;

    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (ras_push) begin
            // Wrapping the pointer overwrites the oldest entry when full.
            ras_ptr_d = ras_ptr_q + RW'(1);
            if (ras_cnt_q != CW'(ras_depth_p)) begin
                ras_cnt_d = ras_cnt_q + CW'(1);
            end
        end else if (ras_pop) begin
            ras_ptr_d = ras_ptr_q - RW'(1);
            ras_cnt_d = ras_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            for (int i = 0; i < ras_depth_p; i++) begin
                ras_mem_q[i] <= '0;
            end
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            if (ras_push) begin
                ras_mem_q[ras_ptr_q] <= s_pc + FB;
            end
        end
    end

`else

    assign k_ret       = 1'b0;
    assign ovr_pc      = resp_tgt_i;
    assign ras_empty_o = 1'b1;

`endif

    // A redirect in the same cycle wins over any predecode override.
    assign ovr = deliver & ~redirect_v_i & (k_tgt | k_ret);

    always_comb begin
        if (redirect_v_i) begin
            fetch_pc_o = redirect_pc_i;
        end else if (ovr) begin
            fetch_pc_o = ovr_pc;
        end else begin
            fetch_pc_o = npc_q;
        end
    end

    always_comb begin
        if (redirect_v_i | fail) begin
            poison_o = '1;
        end else if (ovr) begin
            poison_o = YOUNG;
        end else begin
            poison_o = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        fetch_v_o = redirect_v_i;
        unique case (state_q)
            e_idle: begin
            end
            e_run: begin
                if (!fail) begin
                    fetch_v_o = 1'b1;
                end else if (!redirect_v_i) begin
                    state_d = e_stall;
                end
            end
            e_stall: begin
                if (out_ready_i) begin
                    fetch_v_o = 1'b1;
                end
                if (fetch_v_o & fetch_ready_i) begin
                    state_d = e_run;
                end
            end
            default: state_d = e_idle;
        endcase
        if (redirect_v_i) begin
            state_d = e_run;
        end
    end

    assign issue = fetch_v_o & fetch_ready_i;

    // An unaccepted fetch keeps its PC, so targets are never dropped.
    always_comb begin
        if (fail & ~redirect_v_i) begin
            npc_d = s_pc;
        end else if (issue) begin
            npc_d = fetch_pc_o + FB;
        end else begin
            npc_d = fetch_pc_o;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            npc_q   <= boot_pc_p;
        end else begin
            state_q <= state_d;
            npc_q   <= npc_d;
        end
    end

    // The pipe shifts every cycle; poisoned entries move on as bubbles.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sv_q <= '0;
            for (int i = 0; i < stages_p; i++) begin
                spc_q[i] <= '0;
            end
        end else begin
            sv_q[0]  <= issue;
            spc_q[0] <= fetch_pc_o;
            for (int i = 1; i < stages_p; i++) begin
                sv_q[i]  <= sv_q[i-1] & ~poison_o[i-1];
                spc_q[i] <= spc_q[i-1];
            end
        end
    end

endmodule
